// File: rtl/store_unit_pkg.sv
// Shared store-path constants: funct3 store encodings, region nibbles, IO addresses,
// and the byte-lane generator used by store_unit.
package store_unit_pkg;

  typedef enum logic [2:0] {
    STORE_SB = 3'b000,
    STORE_SH = 3'b001,
    STORE_SW = 3'b010
  } store_f3_e;

  localparam logic [3:0] REGION_IO   = 4'b1000;
  localparam logic [3:0] REGION_BIOS = 4'b0100;

  localparam logic [31:0] IO_UART_TX = 32'h8000_0008;
  localparam logic [31:0] IO_CNT_RST = 32'h8000_0018;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] din;
    logic        misaligned;
  } lane_t;

  // Unknown funct3 yields we=0, which the caller treats as "no write".
  function automatic lane_t store_lanes(input logic [2:0]  f3,
                                        input logic [1:0]  off,
                                        input logic [31:0] data);
    lane_t l;
    l = '0;
    case (f3)
      STORE_SB: begin
        l.we  = 4'b0001 << off;
        l.din = {4{data[7:0]}};
      end
      STORE_SH: begin
        l.we         = 4'b0011 << {off[1], 1'b0};
        l.din        = {2{data[15:0]}};
        l.misaligned = off[0];
      end
      STORE_SW: begin
        l.we         = 4'b1111;
        l.din        = data;
        l.misaligned = |off;
      end
      default: l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/store_unit_uart_tx_fifo.sv
// Synchronous FIFO buffering UART transmit bytes; head entry is read from registered
// storage (no fall-through) and reads as zero when empty.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // No bypass: a full FIFO refuses a push even if it is popped the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/store_unit.sv
// Store-side memory interface: region decode, registered byte-lane writes, UART TX FIFO.
// Optional macro STORE_MISALIGN_TRAP_EN drops misaligned SH/SW and pulses misalign.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int unsigned TX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        pc30,
  output logic        stall,
  output logic [3:0]  dmem_we,
  output logic [13:0] dmem_addr,
  output logic [31:0] dmem_din,
  output logic [3:0]  imem_we,
  output logic [13:0] imem_addr,
  output logic [31:0] imem_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cnt_rst,
  output logic        misalign
);

  lane_t       lanes;
  logic        dmem_hit, imem_hit, io_hit, uart_hit, cnt_hit;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic        drop, wr_ok;

  logic [3:0]  dmem_we_q, dmem_we_d;
  logic [13:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_din_q, dmem_din_d;
  logic [3:0]  imem_we_q, imem_we_d;
  logic [13:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_din_q, imem_din_d;
  logic        cnt_rst_q, cnt_rst_d;

  assign lanes    = store_lanes(st_funct3, st_addr[1:0], st_data);

  assign dmem_hit = (st_addr[31:30] == 2'b00) & st_addr[28];
  assign imem_hit = (st_addr[31:29] == 3'b001) & pc30;
  assign io_hit   = (st_addr[31:28] == REGION_IO);
  assign uart_hit = io_hit & (st_addr == IO_UART_TX);
  assign cnt_hit  = io_hit & (st_addr == IO_CNT_RST);

  assign stall    = st_valid & uart_hit & fifo_full;

`ifdef STORE_MISALIGN_TRAP_EN
  assign drop = lanes.misaligned;
`else
  logic unused_misalign;
  assign unused_misalign = lanes.misaligned;
  assign drop = 1'b0;
`endif

  assign wr_ok     = st_valid & ~stall & ~drop & (|lanes.we);
  assign fifo_push = wr_ok & uart_hit;
  assign fifo_pop  = tx_valid & tx_ready;

  // Addresses/data only advance on a real write so the ports stay quiet otherwise.
  always_comb begin
    dmem_we_d   = '0;
    dmem_addr_d = dmem_addr_q;
    dmem_din_d  = dmem_din_q;
    imem_we_d   = '0;
    imem_addr_d = imem_addr_q;
    imem_din_d  = imem_din_q;
    cnt_rst_d   = wr_ok & cnt_hit;
    if (wr_ok & dmem_hit) begin
      dmem_we_d   = lanes.we;
      dmem_addr_d = st_addr[15:2];
      dmem_din_d  = lanes.din;
    end
    if (wr_ok & imem_hit) begin
      imem_we_d   = lanes.we;
      imem_addr_d = st_addr[15:2];
      imem_din_d  = lanes.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_we_q   <= '0;
      dmem_addr_q <= '0;
      dmem_din_q  <= '0;
      imem_we_q   <= '0;
      imem_addr_q <= '0;
      imem_din_q  <= '0;
      cnt_rst_q   <= 1'b0;
    end else begin
      dmem_we_q   <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_din_q  <= dmem_din_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_din_q  <= imem_din_d;
      cnt_rst_q   <= cnt_rst_d;
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign misalign_d = st_valid & ~stall & (|lanes.we) & lanes.misaligned;
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  uart_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (st_data[7:0]),
    .pop_i   (fifo_pop),
    .dout_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_valid  = ~fifo_empty;
  assign dmem_we   = dmem_we_q;
  assign dmem_addr = dmem_addr_q;
  assign dmem_din  = dmem_din_q;
  assign imem_we   = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_din  = imem_din_q;
  assign cnt_rst   = cnt_rst_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit; expected values are hand-computed.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        pc30;
  logic        stall;
  logic [3:0]  dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_din;
  logic [3:0]  imem_we;
  logic [13:0] imem_addr;
  logic [31:0] imem_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cnt_rst;
  logic        misalign;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  store_unit #(.TX_FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_funct3 (st_funct3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .pc30      (pc30),
    .stall     (stall),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_din  (imem_din),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .cnt_rst   (cnt_rst),
    .misalign  (misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
  endtask

  task automatic idle();
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); st_funct3 = 3'b000; st_addr = '0; st_data = '0;
    pc30 = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    total++; if ({dmem_we, imem_we} !== 8'h00) $display("FAIL reset_we got=%h exp=00", {dmem_we, imem_we}); else passed++;
    total++; if ({dmem_addr, imem_addr} !== 28'h0) $display("FAIL reset_addr got=%h exp=0", {dmem_addr, imem_addr}); else passed++;
    total++; if ({dmem_din, imem_din} !== 64'h0) $display("FAIL reset_din got=%h exp=0", {dmem_din, imem_din}); else passed++;
    total++; if ({tx_valid, tx_data, cnt_rst, misalign, stall} !== 12'h000) $display("FAIL reset_misc got=%h exp=000", {tx_valid, tx_data, cnt_rst, misalign, stall}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_dmem_sb();
    drive(3'b000, 32'h1000_0003, 32'h0000_00AB);
    tick(); idle();
    total++; if (dmem_we !== 4'b1000) $display("FAIL sb_we got=%b exp=1000", dmem_we); else passed++;
    total++; if (dmem_din !== 32'hABAB_ABAB) $display("FAIL sb_din got=%h exp=ababab ab", dmem_din); else passed++;
    total++; if (dmem_addr !== 14'd0) $display("FAIL sb_addr got=%h exp=0", dmem_addr); else passed++;
    total++; if (imem_we !== 4'b0000) $display("FAIL sb_imem_we got=%b exp=0000", imem_we); else passed++;
    tick();
    total++; if (dmem_we !== 4'b0000) $display("FAIL sb_one_cycle got=%b exp=0000", dmem_we); else passed++;
  endtask

  task automatic test_shared_sw();
    pc30 = 1'b1;
    drive(3'b010, 32'h3000_0010, 32'hDEAD_BEEF);
    tick();
    total++; if ({dmem_we, imem_we} !== 8'hFF) $display("FAIL sw_both_we got=%h exp=ff", {dmem_we, imem_we}); else passed++;
    total++; if ({dmem_addr, imem_addr} !== {14'd4, 14'd4}) $display("FAIL sw_both_addr got=%h/%h exp=4/4", dmem_addr, imem_addr); else passed++;
    total++; if ({dmem_din, imem_din} !== {2{32'hDEAD_BEEF}}) $display("FAIL sw_both_din got=%h/%h exp=deadbeef", dmem_din, imem_din); else passed++;
    pc30 = 1'b0;
    drive(3'b010, 32'h3000_0010, 32'hDEAD_BEEF);
    tick(); idle();
    total++; if ({dmem_we, imem_we} !== 8'hF0) $display("FAIL sw_pc30_0 got=%h exp=f0", {dmem_we, imem_we}); else passed++;
  endtask

  task automatic test_ignored();
    pc30 = 1'b1;
    drive(3'b010, 32'h4000_0000, 32'h1111_1111);
    tick();
    total++; if ({dmem_we, imem_we, cnt_rst} !== 9'h000) $display("FAIL bios_ignored got=%h exp=000", {dmem_we, imem_we, cnt_rst}); else passed++;
    drive(3'b011, 32'h1000_0000, 32'h2222_2222);
    tick();
    total++; if (dmem_we !== 4'b0000) $display("FAIL bad_funct3 got=%b exp=0000", dmem_we); else passed++;
    drive(3'b001, 32'h1000_0006, 32'h0000_5678);
    tick(); idle();
    total++; if ({dmem_we, dmem_din} !== {4'b1100, 32'h5678_5678}) $display("FAIL sh_upper got=%b/%h exp=1100/56785678", dmem_we, dmem_din); else passed++;
    total++; if (dmem_addr !== 14'd1) $display("FAIL sh_upper_addr got=%h exp=1", dmem_addr); else passed++;
    pc30 = 1'b0;
  endtask

  task automatic test_misalign();
    drive(3'b001, 32'h1000_0001, 32'h0000_1234);
    tick(); idle();
`ifdef STORE_MISALIGN_TRAP_EN
    total++; if (dmem_we !== 4'b0000) $display("FAIL misalign_we got=%b exp=0000", dmem_we); else passed++;
    total++; if (misalign !== 1'b1) $display("FAIL misalign_pulse got=%b exp=1", misalign); else passed++;
`else
    total++; if (dmem_we !== 4'b0011) $display("FAIL unaligned_sh_we got=%b exp=0011", dmem_we); else passed++;
    total++; if (misalign !== 1'b0) $display("FAIL misalign_tied got=%b exp=0", misalign); else passed++;
`endif
    tick();
    total++; if (misalign !== 1'b0) $display("FAIL misalign_one_cycle got=%b exp=0", misalign); else passed++;
  endtask

  task automatic test_uart_stall();
    logic [7:0] exp_b;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, 32'h8000_0008, 32'h0000_0041 + i);
      #1;
      total++; if (stall !== 1'b0) $display("FAIL uart_push%0d_stall got=%b exp=0", i, stall); else passed++;
      tick();
    end
    total++; if ({tx_valid, tx_data} !== {1'b1, 8'h41}) $display("FAIL uart_head got=%b/%h exp=1/41", tx_valid, tx_data); else passed++;
    drive(3'b000, 32'h8000_0008, 32'h0000_0045);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL uart_full_stall got=%b exp=1", stall); else passed++;
    tick();
    total++; if ({stall, tx_data} !== {1'b1, 8'h41}) $display("FAIL uart_held got=%b/%h exp=1/41", stall, tx_data); else passed++;
    tx_ready = 1'b1;
    tick();
    total++; if ({stall, tx_data} !== {1'b0, 8'h42}) $display("FAIL uart_release got=%b/%h exp=0/42", stall, tx_data); else passed++;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      exp_b = 8'h43 + 8'(i);
      total++; if ({tx_valid, tx_data} !== {1'b1, exp_b}) $display("FAIL uart_drain%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b); else passed++;
      tick();
    end
    total++; if ({tx_valid, tx_data} !== 9'h000) $display("FAIL uart_empty got=%b/%h exp=0/00", tx_valid, tx_data); else passed++;
    tx_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    tx_ready = 1'b0;
    drive(3'b000, 32'h8000_0008, 32'h0000_0050); tick();
    drive(3'b000, 32'h8000_0008, 32'h0000_0051); tick();
    drive(3'b000, 32'h8000_0008, 32'h0000_0052);
    tx_ready = 1'b1;
    #1;
    total++; if (tx_data !== 8'h50) $display("FAIL pp_head got=%h exp=50", tx_data); else passed++;
    tick(); idle();
    total++; if ({tx_valid, tx_data} !== {1'b1, 8'h51}) $display("FAIL pp_after got=%b/%h exp=1/51", tx_valid, tx_data); else passed++;
    tick();
    total++; if ({tx_valid, tx_data} !== {1'b1, 8'h52}) $display("FAIL pp_second got=%b/%h exp=1/52", tx_valid, tx_data); else passed++;
    tick();
    total++; if (tx_valid !== 1'b0) $display("FAIL pp_count2 got=%b exp=0", tx_valid); else passed++;
    tx_ready = 1'b0;
  endtask

  task automatic test_cnt_rst();
    drive(3'b010, 32'h8000_0018, 32'h0000_0001);
    tick(); idle();
    total++; if ({cnt_rst, dmem_we, tx_valid} !== {1'b1, 4'b0000, 1'b0}) $display("FAIL cnt_rst_pulse got=%b/%b/%b exp=1/0000/0", cnt_rst, dmem_we, tx_valid); else passed++;
    tick();
    total++; if (cnt_rst !== 1'b0) $display("FAIL cnt_rst_one_cycle got=%b exp=0", cnt_rst); else passed++;
  endtask

  task automatic test_mid_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, 32'h8000_0008, 32'h0000_0060 + i);
      tick();
    end
    pc30 = 1'b1;
    drive(3'b010, 32'h3000_0000, 32'hCAFE_F00D);
    tick();
    total++; if ({tx_valid, dmem_we, imem_we} !== {1'b1, 8'hFF}) $display("FAIL mr_pending got=%b/%b/%b exp=1/1111/1111", tx_valid, dmem_we, imem_we); else passed++;
    rst = 1'b1;
    drive(3'b010, 32'h3000_0000, 32'hCAFE_F00D);
    tick();
    rst = 1'b0; idle(); pc30 = 1'b0;
    total++; if ({tx_valid, tx_data} !== 9'h000) $display("FAIL mr_fifo got=%b/%h exp=0/00", tx_valid, tx_data); else passed++;
    total++; if ({dmem_we, imem_we, cnt_rst} !== 9'h000) $display("FAIL mr_we got=%h exp=000", {dmem_we, imem_we, cnt_rst}); else passed++;
    total++; if ({dmem_din, imem_din} !== 64'h0) $display("FAIL mr_din got=%h exp=0", {dmem_din, imem_din}); else passed++;
  endtask

  initial begin
    test_reset();
    test_dmem_sb();
    test_shared_sw();
    test_ignored();
    test_misalign();
    test_uart_stall();
    test_push_pop();
    test_cnt_rst();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
